rst_seq_gen: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 35 +++
 rtl/rst_sync.sv | 23 ++
 rtl/rst_seq_gen.sv | 134 +++++++++++++
 tb/tb_rst_seq_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and parameter legality checks for the reset sequencer.
// Imported by rst_seq_gen.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } state_e;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_CNT_W       = 30;

    // Counters run from 0 to X-1, so X-1 must fit in cnt_w bits.
    function automatic bit params_ok(
        input int n_ch,
        input int sync_stages,
        input int hold_cyc,
        input int stagger_cyc,
        input int cnt_w,
        input int ce_div
    );
        bit ok;
        ok = (n_ch >= 1) && (sync_stages >= MIN_SYNC_STAGES) &&
             (hold_cyc >= 1) && (stagger_cyc >= 1) &&
             (ce_div >= 1) && (cnt_w >= 1) && (cnt_w <= MAX_CNT_W);
        if (ok) begin
            ok = ((hold_cyc - 1) < (1 << cnt_w)) &&
                 ((stagger_cyc - 1) < (1 << cnt_w));
        end
        return ok;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchroniser.
// Output rises SYNC_STAGES edges after rst_n is first sampled high.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst_n
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = ff[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronised release, hold, then staggered
// per-channel release, plus a divided clock-enable.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 3,
    parameter int STAGGER_CYC = 1,
    parameter int CNT_W       = 8,
    parameter int CE_DIV      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sw_rst_req,
    output logic [N_CH-1:0] ch_rst_n_o,
    output logic            rst_done_o,
    output logic            busy_o,
    output logic            ce_o
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CE_W  = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CH - 1);
    localparam logic [CE_W-1:0]  CE_LAST   = CE_W'(CE_DIV - 1);

    generate
        if (!params_ok(N_CH, SYNC_STAGES, HOLD_CYC,
                       STAGGER_CYC, CNT_W, CE_DIV)) begin : g_bad_params
            $error("rst_seq_gen: illegal parameter set");
        end
    endgenerate

    logic             sync_rst_n;
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ch_idx;
    logic [CE_W-1:0]  ce_cnt;

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_rst_n (sync_rst_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ASSERT;
            cnt        <= '0;
            ch_idx     <= '0;
            ch_rst_n_o <= '0;
            rst_done_o <= 1'b0;
            busy_o     <= 1'b1;
        end else if (sw_rst_req) begin
            state      <= ST_ASSERT;
            cnt        <= '0;
            ch_idx     <= '0;
            ch_rst_n_o <= '0;
            rst_done_o <= 1'b0;
            busy_o     <= 1'b1;
        end else begin
            unique case (state)
                ST_ASSERT: begin
                    if (sync_rst_n) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt           <= '0;
                        ch_rst_n_o[0] <= 1'b1;
                        ch_idx        <= IDX_W'(1);
                        if (N_CH == 1) begin
                            state      <= ST_DONE;
                            rst_done_o <= 1'b1;
                            busy_o     <= 1'b0;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == STAG_LAST) begin
                        cnt                <= '0;
                        ch_rst_n_o[ch_idx] <= 1'b1;
                        // Last channel out closes the sequence on this edge.
                        if (ch_idx == IDX_LAST) begin
                            state      <= ST_DONE;
                            rst_done_o <= 1'b1;
                            busy_o     <= 1'b0;
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state <= ST_ASSERT;
                end
            endcase
        end
    end

    // Divider ignores sw_rst_req so downstream enables keep their cadence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_cnt <= '0;
            ce_o   <= 1'b0;
        end else if (sync_rst_n) begin
            if (ce_cnt == CE_LAST) begin
                ce_cnt <= '0;
                ce_o   <= 1'b1;
            end else begin
                ce_cnt <= ce_cnt + 1'b1;
                ce_o   <= 1'b0;
            end
        end else begin
            ce_cnt <= '0;
            ce_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: three parameter sets against a timing-formula
// model, plus literal checkpoints from the expected release schedule.
module tb_rst_seq_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic sw_rst_req;

    logic [3:0] ch_o   [3];
    logic       done_o [3];
    logic       busy_o [3];
    logic       ce_o   [3];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int H_A [3] = '{3, 5, 3};
    int S_A [3] = '{1, 3, 1};
    int C_A [3] = '{2, 3, 1};

    int sync_cnt = 0;
    int seq_t [3] = '{-1, -1, -1};
    int m_cnt [3] = '{0, 0, 0};
    bit ce_m  [3] = '{0, 0, 0};
    bit rs;

    always #5 clk = ~clk;

    rst_seq_gen #(
        .N_CH(4), .SYNC_STAGES(2), .HOLD_CYC(3),
        .STAGGER_CYC(1), .CNT_W(8), .CE_DIV(2)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
        .ch_rst_n_o(ch_o[0]), .rst_done_o(done_o[0]),
        .busy_o(busy_o[0]), .ce_o(ce_o[0])
    );

    rst_seq_gen #(
        .N_CH(4), .SYNC_STAGES(2), .HOLD_CYC(5),
        .STAGGER_CYC(3), .CNT_W(8), .CE_DIV(3)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
        .ch_rst_n_o(ch_o[1]), .rst_done_o(done_o[1]),
        .busy_o(busy_o[1]), .ce_o(ce_o[1])
    );

    rst_seq_gen #(
        .N_CH(4), .SYNC_STAGES(2), .HOLD_CYC(3),
        .STAGGER_CYC(1), .CNT_W(8), .CE_DIV(1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
        .ch_rst_n_o(ch_o[2]), .rst_done_o(done_o[2]),
        .busy_o(busy_o[2]), .ce_o(ce_o[2])
    );

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] t=%0t actual=%0h required=%0h",
                     nm, idx, $time, act, exp);
        end
    endtask

    // Channel k is free once HOLD_CYC + k*STAGGER_CYC edges passed since HOLD entry.
    function automatic logic [3:0] exp_ch(input int t, input int h, input int s);
        logic [3:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            if (t >= 0 && t >= h + k * s) v[k] = 1'b1;
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_cnt = 0;
            for (int i = 0; i < 3; i++) begin
                seq_t[i] = -1;
                m_cnt[i] = 0;
                ce_m[i]  = 1'b0;
            end
        end else begin
            rs = (sync_cnt >= 2);
            for (int i = 0; i < 3; i++) begin
                if (sw_rst_req) seq_t[i] = -1;
                else if (seq_t[i] >= 0) begin
                    if (seq_t[i] < 10000) seq_t[i]++;
                end else if (rs) seq_t[i] = 0;
                if (rs) begin
                    m_cnt[i]++;
                    ce_m[i] = ((m_cnt[i] % C_A[i]) == 0);
                end else begin
                    ce_m[i] = 1'b0;
                end
            end
            if (sync_cnt < 100) sync_cnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic [3:0] e;
                e = exp_ch(seq_t[i], H_A[i], S_A[i]);
                chk("model_ch", i, 32'(ch_o[i]), 32'(e));
                chk("model_done", i, 32'(done_o[i]), 32'(e == 4'hF));
                chk("model_busy", i, 32'(busy_o[i]), 32'(e != 4'hF));
                chk("model_ce", i, 32'(ce_o[i]), 32'(ce_m[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic v);
        #1 sw_rst_req = v;
    endtask

    initial begin
        rst_n      = 1'b1;
        sw_rst_req = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        chk("por_ch", 0, 32'(ch_o[0]), 32'h0);
        chk("por_done", 0, 32'(done_o[0]), 32'h0);
        chk("por_busy", 0, 32'(busy_o[0]), 32'h1);
        chk("por_ce", 2, 32'(ce_o[2]), 32'h0);
        repeat (3) step();
        #1 rst_n = 1'b1;

        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 5) chk("pwr_ch_e5", 0, 32'(ch_o[0]), 32'h0);
            if (e == 6) chk("pwr_ch_e6", 0, 32'(ch_o[0]), 32'h1);
            if (e == 7) chk("pwr_ch_e7", 0, 32'(ch_o[0]), 32'h3);
            if (e == 8) begin
                chk("pwr_ch_e8", 0, 32'(ch_o[0]), 32'h7);
                chk("pwr_busy_e8", 0, 32'(busy_o[0]), 32'h1);
                chk("hs_ch_e8", 1, 32'(ch_o[1]), 32'h1);
            end
            if (e == 9) begin
                chk("pwr_ch_e9", 0, 32'(ch_o[0]), 32'hF);
                chk("pwr_done_e9", 0, 32'(done_o[0]), 32'h1);
                chk("pwr_busy_e9", 0, 32'(busy_o[0]), 32'h0);
            end
            if (e == 7)  chk("hs_ch_e7", 1, 32'(ch_o[1]), 32'h0);
            if (e == 10) chk("hs_ch_e10", 1, 32'(ch_o[1]), 32'h1);
            if (e == 11) chk("hs_ch_e11", 1, 32'(ch_o[1]), 32'h3);
            if (e == 14) chk("hs_ch_e14", 1, 32'(ch_o[1]), 32'h7);
            if (e == 16) chk("hs_done_e16", 1, 32'(done_o[1]), 32'h0);
            if (e == 17) begin
                chk("hs_ch_e17", 1, 32'(ch_o[1]), 32'hF);
                chk("hs_done_e17", 1, 32'(done_o[1]), 32'h1);
            end
            if (e == 4) chk("ce2_e4", 0, 32'(ce_o[0]), 32'h1);
            if (e == 5) chk("ce2_e5", 0, 32'(ce_o[0]), 32'h0);
            if (e == 5) chk("ce3_e5", 1, 32'(ce_o[1]), 32'h1);
            if (e == 6) chk("ce3_e6", 1, 32'(ce_o[1]), 32'h0);
            if (e == 2) chk("ce1_e2", 2, 32'(ce_o[2]), 32'h0);
            if (e == 3) chk("ce1_e3", 2, 32'(ce_o[2]), 32'h1);
        end

        // One-cycle software reset while DONE.
        set_sw(1'b1);
        step();
        chk("sw_ch", 0, 32'(ch_o[0]), 32'h0);
        chk("sw_done", 0, 32'(done_o[0]), 32'h0);
        chk("sw_busy", 0, 32'(busy_o[0]), 32'h1);
        set_sw(1'b0);
        repeat (3) step();
        chk("sw_ch_h3", 0, 32'(ch_o[0]), 32'h0);
        step();
        chk("sw_ch_r0", 0, 32'(ch_o[0]), 32'h1);
        step();
        chk("sw_ch_r1", 0, 32'(ch_o[0]), 32'h3);
        repeat (2) step();
        chk("sw_ch_r3", 0, 32'(ch_o[0]), 32'hF);
        chk("sw_done_r3", 0, 32'(done_o[0]), 32'h1);
        repeat (12) step();

        // Restart, then hold sw_rst_req for 4 edges at ch=0011.
        set_sw(1'b1);
        step();
        set_sw(1'b0);
        repeat (5) step();
        chk("hold_pre_ch", 0, 32'(ch_o[0]), 32'h3);
        set_sw(1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold_sw_ch", 0, 32'(ch_o[0]), 32'h0);
            chk("hold_sw_busy", 0, 32'(busy_o[0]), 32'h1);
        end
        set_sw(1'b0);
        step();
        step();
        chk("hold_mid_ch", 0, 32'(ch_o[0]), 32'h0);
        chk("pre_rst_ce1", 2, 32'(ce_o[2]), 32'h1);

        // Async rst_n mid-HOLD: outputs drop before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("async_ch", i, 32'(ch_o[i]), 32'h0);
            chk("async_busy", i, 32'(busy_o[i]), 32'h1);
            chk("async_done", i, 32'(done_o[i]), 32'h0);
            chk("async_ce", i, 32'(ce_o[i]), 32'h0);
        end
        repeat (2) step();
        chk("rstlow_ce1", 2, 32'(ce_o[2]), 32'h0);
        #1 rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 5) chk("rerel_ch_e5", 0, 32'(ch_o[0]), 32'h0);
            if (e == 6) chk("rerel_ch_e6", 0, 32'(ch_o[0]), 32'h1);
            if (e == 2) chk("rerel_ce1_e2", 2, 32'(ce_o[2]), 32'h0);
            if (e == 3) chk("rerel_ce1_e3", 2, 32'(ce_o[2]), 32'h1);
        end
        repeat (14) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
